mix_col_seq: RTL
================

MIX_COL_SEQ -- requirements
Module: mix_col_seq

Interface
REQ-001 SHALL have parameter: none; all widths fixed (128-bit state, 32-bit column, 8-bit byte).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  in_state/in_inv valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a state.
REQ-006 SHALL have port: in_state  input  128  AES state; byte b at [127-8b -: 8], column c = bytes 4c..4c+3 (row 0 first).
REQ-007 SHALL have port: in_inv  input  1  0 = MixColumns, 1 = InvMixColumns.
REQ-008 SHALL have port: out_valid  output  1  out_state valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts out_state.
REQ-010 SHALL have port: out_state  output  128  transformed state, same byte layout.
REQ-011 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL time-share one combinational column mixer (4 bytes in, 4 bytes out, GF(2^8), polynomial 0x11B, xtime = shift-left XOR 0x1B when bit7 set) across the four columns.
REQ-013 SHALL use FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
REQ-014 IDLE: on in_valid&&in_ready SHALL capture in_state into working register, latch in_inv, clear column counter col to 0, go RUN.
REQ-015 RUN: each cycle SHALL replace column col of the working register with mixer(column col), increment col; after col==3 is written SHALL go DONE, col wraps to 0.
REQ-016 Forward mixer SHALL compute r0=2a0^3a1^a2^a3, r1=a0^2a1^3a2^a3, r2=a0^a1^2a2^3a3, r3=3a0^a1^a2^2a3.
REQ-017 Inverse mixer SHALL compute r0=e a0^b a1^d a2^9 a3, rotated likewise per row (coefficients e,b,d,9).
REQ-018 Latency SHALL be exactly 4 cycles: acceptance at edge k -> out_valid high after edge k+4.
REQ-019 DONE: out_state SHALL equal working register and stay stable while out_valid&&!out_ready; on out_ready SHALL go IDLE the same edge.
REQ-020 SHALL not accept a new state in RUN or DONE; max throughput one state per 6 cycles.
REQ-021 in_state/in_inv changes during RUN/DONE SHALL have no effect on the result.
REQ-022 out_state outside DONE SHALL be the working register value (no zeroing required); consumers use out_valid only.

Reset
REQ-023 rst_n low SHALL asynchronously force state=IDLE, col=0, working register=0, latched inv=0.
REQ-024 After reset: in_ready=1, out_valid=0, busy=0, out_state=0.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abandon the operation; no out_valid for it after release.

Configuration
REQ-026 Macro MIX_COL_SEQ_INV_EN: defined -> inverse mixer built, in_inv honoured per REQ-017.
REQ-027 MIX_COL_SEQ_INV_EN undefined -> inverse mixer omitted, in_inv ignored, always forward MixColumns; port list unchanged.

Verification
REQ-028 Forward: in_state=db135345_f20a225c_01010101_c6c6c6c6, in_inv=0 -> out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid exactly 4 cycles after accept.
REQ-029 Inverse (MIX_COL_SEQ_INV_EN defined): in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_inv=1 -> out_state=db135345_f20a225c_01010101_c6c6c6c6; undefined -> forward result of that input.
REQ-030 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, out_state (d4d4d4d5_2d26314c_... -> d5d5d7d6_4d7ebdf8_...) stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-031 Stimulus stability: toggle in_state/in_inv randomly during RUN -> result identical to REQ-028.
REQ-032 Reset mid-op: rst_n low at col==2 -> immediately in_ready=1, busy=0, out_state=0; no out_valid after release until new accept.
REQ-033 Back-to-back: in_valid held high with two states, out_ready=1 -> second accept 6 cycles after first, both results correct and in order.

Source files
------------

// File: rtl/mix_col_seq.sv
// Sequential AES (Inv)MixColumns: one shared column mixer processes the four columns over four cycles.
// Define MIX_COL_SEQ_INV_EN to build the inverse mixer; otherwise in_inv is ignored and only the forward transform is built.
module mix_col_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       r_state;
  logic [1:0]   r_col;
  logic [127:0] r_work;

  logic [31:0]  w_col_in;
  logic [31:0]  w_col_out;
  logic [7:0]   w_a   [4];
  logic [7:0]   w_fwd [4];
  logic [7:0]   w_r   [4];
  logic         w_inv;

  function automatic logic [7:0] f_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    w_col_in = r_work[127:96];
    case (r_col)
      2'd0: w_col_in = r_work[127:96];
      2'd1: w_col_in = r_work[95:64];
      2'd2: w_col_in = r_work[63:32];
      2'd3: w_col_in = r_work[31:0];
      default: w_col_in = r_work[127:96];
    endcase
  end

`ifdef MIX_COL_SEQ_INV_EN
  logic       r_inv;
  logic [7:0] w_x9  [4];
  logic [7:0] w_x11 [4];
  logic [7:0] w_x13 [4];
  logic [7:0] w_x14 [4];
  logic [7:0] w_invr[4];
  assign w_inv = r_inv;
`else
  logic w_unused_inv;
  assign w_unused_inv = in_inv;
  assign w_inv = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign w_a[gi] = w_col_in[31-8*gi -: 8];
      // 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3), rows rotate through the same column
      assign w_fwd[gi] = f_xtime(w_a[gi]) ^ f_xtime(w_a[(gi+1)%4]) ^ w_a[(gi+1)%4]
                       ^ w_a[(gi+2)%4] ^ w_a[(gi+3)%4];
`ifdef MIX_COL_SEQ_INV_EN
      logic [7:0] w_x2, w_x4, w_x8;
      assign w_x2 = f_xtime(w_a[gi]);
      assign w_x4 = f_xtime(w_x2);
      assign w_x8 = f_xtime(w_x4);
      assign w_x9[gi]  = w_x8 ^ w_a[gi];
      assign w_x11[gi] = w_x8 ^ w_x2 ^ w_a[gi];
      assign w_x13[gi] = w_x8 ^ w_x4 ^ w_a[gi];
      assign w_x14[gi] = w_x8 ^ w_x4 ^ w_x2;
      assign w_invr[gi] = w_x14[gi] ^ w_x11[(gi+1)%4] ^ w_x13[(gi+2)%4] ^ w_x9[(gi+3)%4];
      assign w_r[gi] = w_inv ? w_invr[gi] : w_fwd[gi];
`else
      assign w_r[gi] = w_inv ? w_fwd[gi] : w_fwd[gi];
`endif
    end
  endgenerate

  assign w_col_out = {w_r[0], w_r[1], w_r[2], w_r[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_col   <= 2'd0;
      r_work  <= 128'd0;
`ifdef MIX_COL_SEQ_INV_EN
      r_inv   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work  <= in_state;
            r_col   <= 2'd0;
            r_state <= RUN;
`ifdef MIX_COL_SEQ_INV_EN
            r_inv   <= in_inv;
`endif
          end
        end
        RUN: begin
          case (r_col)
            2'd0: r_work[127:96] <= w_col_out;
            2'd1: r_work[95:64]  <= w_col_out;
            2'd2: r_work[63:32]  <= w_col_out;
            2'd3: r_work[31:0]   <= w_col_out;
            default: r_work[127:96] <= w_col_out;
          endcase
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_state = r_work;

endmodule
